// File: rtl/fmac_arbiter.sv
// fmac_arbiter: shares a single fixed-latency FMAC pipeline between two
// requesters and returns each result to a per-requester FIFO.
//
// Ports:
//   Clk_CI, Rst_RI            clock (rising edge), async active-high reset
//   Valid_x_SI / Ready_x_SO   operation request / acceptance, x = 0,1
//   Opnd_x_DI, Rm_x_DI        operands {A,B,C} (A in MSBs) and rounding mode
//   Fmac_valid_SO             operation issued to the FMAC this cycle
//   Fmac_opnd_DO, Fmac_rm_DO  issued operands / rounding mode (0 when idle)
//   Fmac_res_DI               FMAC result, valid C_LAT cycles after issue
//   Res_valid_x_SO            result FIFO x non-empty
//   Res_ready_x_SI            requester x consumes the head result
//   Res_x_DO                  head of result FIFO x (0 when empty)
//   Busy_SO                   operation in flight or any FIFO non-empty
//
// Build option: define FMAC_ARB_FIXED_PRIO_EN to give requester 0 absolute
// priority (round-robin state removed); otherwise requesters alternate.
module fmac_arbiter #(
    parameter int unsigned C_OP  = 32,
    parameter int unsigned C_LAT = 3,
    parameter int unsigned C_BUF = 4
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              Valid_0_SI,
    input  logic              Valid_1_SI,
    output logic              Ready_0_SO,
    output logic              Ready_1_SO,
    input  logic [3*C_OP-1:0] Opnd_0_DI,
    input  logic [3*C_OP-1:0] Opnd_1_DI,
    input  logic [2:0]        Rm_0_DI,
    input  logic [2:0]        Rm_1_DI,
    output logic              Fmac_valid_SO,
    output logic [3*C_OP-1:0] Fmac_opnd_DO,
    output logic [2:0]        Fmac_rm_DO,
    input  logic [C_OP-1:0]   Fmac_res_DI,
    output logic              Res_valid_0_SO,
    output logic              Res_valid_1_SO,
    input  logic              Res_ready_0_SI,
    input  logic              Res_ready_1_SI,
    output logic [C_OP-1:0]   Res_0_DO,
    output logic [C_OP-1:0]   Res_1_DO,
    output logic              Busy_SO
);

    localparam int unsigned CW = $clog2(C_BUF + 1);
    localparam int unsigned PW = (C_BUF > 1) ? $clog2(C_BUF) : 1;

    logic [1:0]        valid_v;
    logic [1:0]        rready_v;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic [1:0]        nonempty;
    logic [C_OP-1:0]   head [2];

    logic [C_LAT-1:0]  tag_v_q, tag_v_d;
    logic [C_LAT-1:0]  tag_id_q, tag_id_d;

    assign valid_v  = {Valid_1_SI, Valid_0_SI};
    assign rready_v = {Res_ready_1_SI, Res_ready_0_SI};

`ifdef FMAC_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = '0;
        if (!Rst_RI) begin
            gnt[0] = elig[0];
            gnt[1] = elig[1] && !elig[0];
        end
    end
`else
    // last_q holds the id of the most recent grant; reset to 1 so that
    // requester 0 wins the first contested cycle.
    logic last_q, last_d;

    always_comb begin
        gnt = '0;
        if (!Rst_RI) begin
            if (elig == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = elig;
            end
        end
        last_d = last_q;
        if (gnt != '0) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        Ready_0_SO    = gnt[0];
        Ready_1_SO    = gnt[1];
        Fmac_valid_SO = gnt[0] || gnt[1];
        Fmac_opnd_DO  = '0;
        Fmac_rm_DO    = '0;
        if (gnt[0]) begin
            Fmac_opnd_DO = Opnd_0_DI;
            Fmac_rm_DO   = Rm_0_DI;
        end else if (gnt[1]) begin
            Fmac_opnd_DO = Opnd_1_DI;
            Fmac_rm_DO   = Rm_1_DI;
        end
    end

    // Tag pipeline mirrors the FMAC: the last stage names the FIFO that
    // receives Fmac_res_DI at the end of the current cycle.
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = Fmac_valid_SO;
        tag_id_d[0] = gnt[1];
        for (int unsigned i = 1; i < C_LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_req
        logic [C_OP-1:0] mem_q [C_BUF];
        logic [C_OP-1:0] mem_d [C_BUF];
        logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic [CW-1:0]   credit_q, credit_d;
        logic            push, pop;

        assign push        = tag_v_q[C_LAT-1] && (tag_id_q[C_LAT-1] == 1'(g));
        assign pop         = rready_v[g] && (cnt_q != '0);
        assign elig[g]     = valid_v[g] && (credit_q != '0);
        assign nonempty[g] = (cnt_q != '0);
        assign head[g]     = nonempty[g] ? mem_q[rd_q] : '0;

        // Credits reserve a FIFO slot at issue time, so push never meets a
        // full FIFO and no overflow check is needed.
        always_comb begin
            mem_d    = mem_q;
            wr_d     = wr_q;
            rd_d     = rd_q;
            if (push) begin
                mem_d[wr_q] = Fmac_res_DI;
                wr_d = (wr_q == PW'(C_BUF - 1)) ? '0 : wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = (rd_q == PW'(C_BUF - 1)) ? '0 : rd_q + PW'(1);
            end
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
            credit_d = credit_q + CW'(pop) - CW'(gnt[g]);
        end

        always_ff @(posedge Clk_CI or posedge Rst_RI) begin
            if (Rst_RI) begin
                wr_q     <= '0;
                rd_q     <= '0;
                cnt_q    <= '0;
                credit_q <= CW'(C_BUF);
            end else begin
                wr_q     <= wr_d;
                rd_q     <= rd_d;
                cnt_q    <= cnt_d;
                credit_q <= credit_d;
            end
        end

        // Storage needs no reset: the head is masked while the FIFO is empty.
        always_ff @(posedge Clk_CI) begin
            mem_q <= mem_d;
        end
    end

    assign Res_valid_0_SO = nonempty[0];
    assign Res_valid_1_SO = nonempty[1];
    assign Res_0_DO       = head[0];
    assign Res_1_DO       = head[1];
    assign Busy_SO        = (tag_v_q != '0) || (nonempty != '0);

endmodule

// File: tb/tb_fmac_arbiter.sv
// tb_fmac_arbiter: scoreboard bench for fmac_arbiter. A behavioural FMAC
// computes (A*B+C)^rm from the issued operands; the expected result is
// computed from the operands the bench itself presented.
module tb_fmac_arbiter;

    localparam int unsigned C_OP  = 32;
    localparam int unsigned C_LAT = 3;
    localparam int unsigned C_BUF = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              Valid_0_SI = 1'b0, Valid_1_SI = 1'b0;
    logic              Ready_0_SO, Ready_1_SO;
    logic [3*C_OP-1:0] Opnd_0_DI = '0, Opnd_1_DI = '0;
    logic [2:0]        Rm_0_DI = '0, Rm_1_DI = '0;
    logic              Fmac_valid_SO;
    logic [3*C_OP-1:0] Fmac_opnd_DO;
    logic [2:0]        Fmac_rm_DO;
    logic [C_OP-1:0]   Fmac_res_DI = '0;
    logic              Res_valid_0_SO, Res_valid_1_SO;
    logic              Res_ready_0_SI = 1'b0, Res_ready_1_SI = 1'b0;
    logic [C_OP-1:0]   Res_0_DO, Res_1_DO;
    logic              Busy_SO;

    fmac_arbiter #(.C_OP(C_OP), .C_LAT(C_LAT), .C_BUF(C_BUF)) dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .Valid_0_SI(Valid_0_SI), .Valid_1_SI(Valid_1_SI),
        .Ready_0_SO(Ready_0_SO), .Ready_1_SO(Ready_1_SO),
        .Opnd_0_DI(Opnd_0_DI), .Opnd_1_DI(Opnd_1_DI),
        .Rm_0_DI(Rm_0_DI), .Rm_1_DI(Rm_1_DI),
        .Fmac_valid_SO(Fmac_valid_SO), .Fmac_opnd_DO(Fmac_opnd_DO),
        .Fmac_rm_DO(Fmac_rm_DO), .Fmac_res_DI(Fmac_res_DI),
        .Res_valid_0_SO(Res_valid_0_SO), .Res_valid_1_SO(Res_valid_1_SO),
        .Res_ready_0_SI(Res_ready_0_SI), .Res_ready_1_SI(Res_ready_1_SI),
        .Res_0_DO(Res_0_DO), .Res_1_DO(Res_1_DO), .Busy_SO(Busy_SO)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [C_OP-1:0] data; int rdy; } sb_t;
    typedef struct { logic [C_OP-1:0] data; int due; } fm_t;

    sb_t sb[$];
    fm_t fmq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int want[2];
    int outst[2];
    int gcnt[2];
    bit gdone[2];
    bit last = 1'b1;
    bit rrand = 1'b0;
    logic rrdy[2];
    logic [3*C_OP-1:0] opnd_i[2];
    logic [2:0] rm_i[2];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [C_OP-1:0] fm(input logic [3*C_OP-1:0] o, input logic [2:0] r);
        logic [C_OP-1:0] a, b, c;
        a = o[3*C_OP-1:2*C_OP];
        b = o[2*C_OP-1:C_OP];
        c = o[C_OP-1:0];
        return (a * b + c) ^ C_OP'(r);
    endfunction

    task automatic monitor();
        bit e0, e1, busy_exp, expv;
        int g, idx;
        logic rv[2];
        logic [C_OP-1:0] rd[2];
        logic rr[2];
        rv = '{Res_valid_0_SO, Res_valid_1_SO};
        rd = '{Res_0_DO, Res_1_DO};
        rr = '{Res_ready_0_SI, Res_ready_1_SI};

        busy_exp = 1'b0;
        foreach (sb[i]) if (sb[i].rdy <= cyc + C_LAT) busy_exp = 1'b1;
        check_val("busy", 128'(Busy_SO), 128'(busy_exp));

        e0 = (want[0] > 0) && (outst[0] < C_BUF);
        e1 = (want[1] > 0) && (outst[1] < C_BUF);
        g = -1;
`ifdef FMAC_ARB_FIXED_PRIO_EN
        if (e0) g = 0; else if (e1) g = 1;
`else
        if (e0 && e1) g = last ? 0 : 1;
        else if (e0) g = 0;
        else if (e1) g = 1;
`endif
        check_val("ready0", 128'(Ready_0_SO), 128'(g == 0));
        check_val("ready1", 128'(Ready_1_SO), 128'(g == 1));
        check_val("fmac_valid", 128'(Fmac_valid_SO), 128'(g >= 0));
        if (g >= 0) begin
            check_val("fmac_opnd", 128'(Fmac_opnd_DO), 128'(opnd_i[g]));
            check_val("fmac_rm", 128'(Fmac_rm_DO), 128'(rm_i[g]));
            sb.push_back('{g, fm(opnd_i[g], rm_i[g]), cyc + C_LAT + 1});
            fmq.push_back('{fm(Fmac_opnd_DO, Fmac_rm_DO), cyc + C_LAT});
            want[g]--; outst[g]++; gcnt[g]++; gdone[g] = 1'b1; last = (g == 1);
        end else begin
            check_val("fmac_opnd_idle", 128'(Fmac_opnd_DO), 128'(0));
            check_val("fmac_rm_idle", 128'(Fmac_rm_DO), 128'(0));
        end

        for (int x = 0; x < 2; x++) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].id == x) idx = i;
            expv = (idx >= 0) && (sb[idx].rdy <= cyc);
            check_val($sformatf("res_valid%0d", x), 128'(rv[x]), 128'(expv));
            if (expv && rr[x] === 1'b1) begin
                check_val($sformatf("res_data%0d", x), 128'(rd[x]), 128'(sb[idx].data));
                sb.delete(idx);
                outst[x]--;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (fmq.size() > 0 && fmq[0].due == cyc) begin
            Fmac_res_DI = fmq[0].data;
            void'(fmq.pop_front());
        end else begin
            Fmac_res_DI = $urandom;
        end
        for (int x = 0; x < 2; x++) begin
            if (gdone[x]) begin
                opnd_i[x] = {$urandom, $urandom, $urandom};
                rm_i[x]   = 3'($urandom_range(0, 7));
                gdone[x]  = 1'b0;
            end
        end
        Valid_0_SI     = want[0] > 0;
        Valid_1_SI     = want[1] > 0;
        Opnd_0_DI      = opnd_i[0];
        Opnd_1_DI      = opnd_i[1];
        Rm_0_DI        = rm_i[0];
        Rm_1_DI        = rm_i[1];
        Res_ready_0_SI = rrand ? 1'($urandom_range(0, 1)) : rrdy[0];
        Res_ready_1_SI = rrand ? 1'($urandom_range(0, 1)) : rrdy[1];
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset asserted mid-cycle with a request pending: every output must
    // drop at once, before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        want = '{0, 0};
        Valid_0_SI = 1'b1;
        Valid_1_SI = 1'b1;
        rst = 1'b1;
        #1;
        check_val("rst_ready0", 128'(Ready_0_SO), 128'(0));
        check_val("rst_ready1", 128'(Ready_1_SO), 128'(0));
        check_val("rst_fvalid", 128'(Fmac_valid_SO), 128'(0));
        check_val("rst_fopnd", 128'(Fmac_opnd_DO), 128'(0));
        check_val("rst_frm", 128'(Fmac_rm_DO), 128'(0));
        check_val("rst_rvalid0", 128'(Res_valid_0_SO), 128'(0));
        check_val("rst_rvalid1", 128'(Res_valid_1_SO), 128'(0));
        check_val("rst_res0", 128'(Res_0_DO), 128'(0));
        check_val("rst_res1", 128'(Res_1_DO), 128'(0));
        check_val("rst_busy", 128'(Busy_SO), 128'(0));
        sb.delete();
        fmq.delete();
        outst = '{0, 0};
        last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Valid_0_SI = 1'b0;
        Valid_1_SI = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        want = '{0, 0}; outst = '{0, 0}; gcnt = '{0, 0}; gdone = '{0, 0};
        rrdy = '{1'b1, 1'b1};
        opnd_i = '{96'h0, 96'h0}; rm_i = '{3'd0, 3'd0};
        do_reset();

        // Single op: 0*0 + 0x3F800000 with rm 0 -> 0x3F800000 after C_LAT+1
        opnd_i[0] = {32'h0, 32'h0, 32'h3F80_0000};
        rm_i[0] = 3'd0;
        opnd_i[1] = {$urandom, $urandom, $urandom};
        want[0] = 1;
        run(8);

        // Both requesters busy, consumers always ready
        want = '{8, 8};
        run(24);

        // Requester 1 starved of credits, then one pop releases one grant
        rrdy = '{1'b1, 1'b0};
        gcnt = '{0, 0};
        want[1] = 6;
        run(12);
        check_val("credit_limit", 128'(gcnt[1]), 128'(C_BUF));
        rrdy[1] = 1'b1; run(1);
        rrdy[1] = 1'b0; run(2);
        check_val("credit_return", 128'(gcnt[1]), 128'(C_BUF + 1));
        rrdy[1] = 1'b1;
        run(16);

        // FIFO 0 full, then pop coinciding with an incoming write
        rrdy = '{1'b0, 1'b1};
        want[0] = 5;
        run(10);
        rrdy[0] = 1'b1; run(1);
        rrdy[0] = 1'b0; run(3);
        rrdy[0] = 1'b1; run(1);
        rrdy[0] = 1'b0; run(4);
        rrdy[0] = 1'b1; run(12);

        // Random consumer back-pressure
        rrand = 1'b1;
        want = '{12, 12};
        run(80);
        rrand = 1'b0;
        rrdy = '{1'b1, 1'b1};
        run(30);
        check_val("drain_sb", 128'(sb.size()), 128'(0));
        check_val("drain_want", 128'(want[0] + want[1]), 128'(0));

        // Reset with ops in flight: results after release must be dropped
        want = '{1, 1};
        run(3);
        do_reset();
        run(10);

        // Credits restored to full after reset
        rrdy = '{1'b1, 1'b0};
        gcnt = '{0, 0};
        want[1] = 6;
        run(12);
        check_val("credit_after_rst", 128'(gcnt[1]), 128'(C_BUF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
